// File: rtl/de2_key_debouncer.sv
// Debouncer for the active-low DE2 pushbuttons: 2-FF sync plus a per-key four-state qualifier.
// Optional glitch abort counter enabled by defining DE2_KEY_DEBOUNCER_GLITCH_CNT_EN.
module de2_key_debouncer #(
    parameter int NUM_KEYS        = 4,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] key_n_in,
    output logic [NUM_KEYS-1:0] key_out,
    output logic [NUM_KEYS-1:0] press_pulse,
    output logic [NUM_KEYS-1:0] release_pulse
`ifdef DE2_KEY_DEBOUNCER_GLITCH_CNT_EN
    ,
    input  logic                glitch_clr,
    output logic [15:0]         glitch_count
`endif
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {REL, CHK_P, PRS, CHK_R} state_e;

    logic [NUM_KEYS-1:0] sync1_q, sync1_d;
    logic [NUM_KEYS-1:0] sync2_q, sync2_d;
    logic [NUM_KEYS-1:0] key_out_q, key_out_d;
    logic [NUM_KEYS-1:0] press_q, press_d;
    logic [NUM_KEYS-1:0] release_q, release_d;
    logic [NUM_KEYS-1:0] s_act;
    state_e              state_q [NUM_KEYS];
    state_e              state_d [NUM_KEYS];
    logic [CNT_W-1:0]    cnt_q   [NUM_KEYS];
    logic [CNT_W-1:0]    cnt_d   [NUM_KEYS];

    // NOTE: every signal written here gets a default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        sync1_d   = key_n_in;
        sync2_d   = sync1_q;
        s_act     = ~sync2_q;
        key_out_d = key_out_q;
        press_d   = '0;
        release_d = '0;
        for (int k = 0; k < NUM_KEYS; k++) begin
            state_d[k] = state_q[k];
            cnt_d[k]   = cnt_q[k];
            case (state_q[k])
                REL: begin
                    if (s_act[k]) begin
                        state_d[k] = CHK_P;
                        cnt_d[k]   = CNT_ONE;
                    end else begin
                        cnt_d[k] = '0;
                    end
                end
                CHK_P: begin
                    if (!s_act[k]) begin
                        state_d[k] = REL;
                        cnt_d[k]   = '0;
                    end else if (cnt_q[k] == CNT_LAST) begin
                        state_d[k]   = PRS;
                        cnt_d[k]     = '0;
                        key_out_d[k] = 1'b1;
                        press_d[k]   = 1'b1;
                    end else begin
                        cnt_d[k] = cnt_q[k] + CNT_ONE;
                    end
                end
                PRS: begin
                    if (!s_act[k]) begin
                        state_d[k] = CHK_R;
                        cnt_d[k]   = CNT_ONE;
                    end else begin
                        cnt_d[k] = '0;
                    end
                end
                CHK_R: begin
                    if (s_act[k]) begin
                        state_d[k] = PRS;
                        cnt_d[k]   = '0;
                    end else if (cnt_q[k] == CNT_LAST) begin
                        state_d[k]   = REL;
                        cnt_d[k]     = '0;
                        key_out_d[k] = 1'b0;
                        release_d[k] = 1'b1;
                    end else begin
                        cnt_d[k] = cnt_q[k] + CNT_ONE;
                    end
                end
                default: begin
                    state_d[k] = REL;
                    cnt_d[k]   = '0;
                end
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q   <= '1;
            sync2_q   <= '1;
            key_out_q <= '0;
            press_q   <= '0;
            release_q <= '0;
            for (int k = 0; k < NUM_KEYS; k++) begin
                state_q[k] <= REL;
                cnt_q[k]   <= '0;
            end
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            key_out_q <= key_out_d;
            press_q   <= press_d;
            release_q <= release_d;
            for (int k = 0; k < NUM_KEYS; k++) begin
                state_q[k] <= state_d[k];
                cnt_q[k]   <= cnt_d[k];
            end
        end
    end

    assign key_out       = key_out_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;

`ifdef DE2_KEY_DEBOUNCER_GLITCH_CNT_EN
    logic [15:0] glitch_count_q, glitch_count_d;
    logic        abort_any;

    // An abort is a checking state seeing its level fall back before qualification.
    always_comb begin
        abort_any = 1'b0;
        for (int k = 0; k < NUM_KEYS; k++) begin
            if ((state_q[k] == CHK_P && !s_act[k]) || (state_q[k] == CHK_R && s_act[k])) begin
                abort_any = 1'b1;
            end
        end
        glitch_count_d = glitch_count_q;
        if (glitch_clr) begin
            glitch_count_d = '0;
        end else if (abort_any && glitch_count_q != 16'hFFFF) begin
            glitch_count_d = glitch_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            glitch_count_q <= '0;
        end else begin
            glitch_count_q <= glitch_count_d;
        end
    end

    assign glitch_count = glitch_count_q;
`endif

endmodule

// File: tb/tb_de2_key_debouncer.sv
// Self-checking bench for de2_key_debouncer: strobe scoreboard plus per-scenario inline checks.
// Define DE2_KEY_DEBOUNCER_GLITCH_CNT_EN to also exercise the glitch counter.
module tb_de2_key_debouncer;

    localparam int NK  = 4;
    localparam int DC  = 8;
    localparam int LAT = DC + 2;

    typedef struct {
        int         cyc;
        logic [3:0] press;
        logic [3:0] rel;
        logic [3:0] kout;
    } ev_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [NK-1:0] key_n_in = 4'hF;
    logic [NK-1:0] key_out;
    logic [NK-1:0] press_pulse;
    logic [NK-1:0] release_pulse;
`ifdef DE2_KEY_DEBOUNCER_GLITCH_CNT_EN
    logic          glitch_clr = 1'b0;
    logic [15:0]   glitch_count;
`endif

    int  cyc = 0;
    int  n_checks = 0;
    int  n_errors = 0;
    ev_t sb[$];

    de2_key_debouncer #(
        .NUM_KEYS       (NK),
        .DEBOUNCE_CYCLES(DC)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .key_n_in     (key_n_in),
        .key_out      (key_out),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse)
`ifdef DE2_KEY_DEBOUNCER_GLITCH_CNT_EN
        ,
        .glitch_clr   (glitch_clr),
        .glitch_count (glitch_count)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at time %0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end

    // Strobe monitor: every strobe must match the oldest expected event on the exact cycle.
    always @(negedge clk) begin
        ev_t e;
        if (cyc > 1 && (press_pulse | release_pulse) !== 4'h0) begin
            n_checks++;
            if ((press_pulse & release_pulse) !== 4'h0) begin
                n_errors++;
                $display("FAIL strobe_overlap: press=%h release=%h, required disjoint", press_pulse, release_pulse);
            end
            n_checks++;
            if (sb.size() == 0) begin
                n_errors++;
                $display("FAIL unexpected_strobe: press=%h release=%h key_out=%h at cycle %0d, required none",
                         press_pulse, release_pulse, key_out, cyc);
            end else begin
                e = sb.pop_front();
                if (cyc != e.cyc || press_pulse !== e.press || release_pulse !== e.rel || key_out !== e.kout) begin
                    n_errors++;
                    $display("FAIL strobe_event: cycle=%0d press=%h release=%h key_out=%h, required cycle=%0d press=%h release=%h key_out=%h",
                             cyc, press_pulse, release_pulse, key_out, e.cyc, e.press, e.rel, e.kout);
                end
            end
        end else if (sb.size() != 0 && cyc > sb[0].cyc) begin
            e = sb.pop_front();
            n_checks++;
            n_errors++;
            $display("FAIL missing_strobe: none by cycle %0d, required press=%h release=%h at cycle %0d",
                     cyc, e.press, e.rel, e.cyc);
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    function automatic void push_ev(input int c, input logic [3:0] p, input logic [3:0] r, input logic [3:0] k);
        ev_t e;
        e.cyc   = c;
        e.press = p;
        e.rel   = r;
        e.kout  = k;
        sb.push_back(e);
    endfunction

    task automatic wait_drain(input int budget, input string name);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            step();
            n++;
        end
        step();
        n_checks++;
        if (sb.size() != 0) begin
            n_errors++;
            $display("FAIL %s_drain: %0d events pending, required 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic check_kout(input logic [3:0] exp, input string name);
        n_checks++;
        if (key_out !== exp) begin
            n_errors++;
            $display("FAIL %s: key_out=%h at cycle %0d, required %h", name, key_out, cyc, exp);
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 50; i++) begin
            step();
            n_checks++;
            if (key_out !== 4'h0 || press_pulse !== 4'h0 || release_pulse !== 4'h0) begin
                n_errors++;
                $display("FAIL reset_hold: key_out=%h press=%h release=%h, required 0/0/0",
                         key_out, press_pulse, release_pulse);
            end
        end
        reset = 1'b0;
        for (int i = 0; i < 50; i++) begin
            step();
            check_kout(4'h0, "idle_released");
        end
`ifdef DE2_KEY_DEBOUNCER_GLITCH_CNT_EN
        n_checks++;
        if (glitch_count !== 16'h0) begin
            n_errors++;
            $display("FAIL glitch_reset: glitch_count=%h, required 0000", glitch_count);
        end
`endif
    endtask

    task automatic test_press_release();
        key_n_in[0] = 1'b0;
        push_ev(cyc + LAT, 4'h1, 4'h0, 4'h1);
        for (int i = 1; i <= LAT + 1; i++) begin
            step();
            check_kout((i >= LAT) ? 4'h1 : 4'h0, "press_latency");
        end
        n_checks++;
        if (press_pulse !== 4'h0) begin
            n_errors++;
            $display("FAIL press_one_cycle: press=%h, required 0", press_pulse);
        end
        key_n_in[0] = 1'b1;
        push_ev(cyc + LAT, 4'h0, 4'h1, 4'h0);
        for (int i = 1; i <= LAT + 1; i++) begin
            step();
            check_kout((i >= LAT) ? 4'h0 : 4'h1, "release_latency");
        end
        wait_drain(LAT + 4, "press_release");
    endtask

    task automatic test_glitch();
`ifdef DE2_KEY_DEBOUNCER_GLITCH_CNT_EN
        glitch_clr = 1'b1;
        step();
        glitch_clr = 1'b0;
        n_checks++;
        if (glitch_count !== 16'h0) begin
            n_errors++;
            $display("FAIL glitch_pre_clear: glitch_count=%h, required 0000", glitch_count);
        end
`endif
        for (int r = 0; r < 5; r++) begin
            key_n_in[1] = 1'b0;
            for (int i = 0; i < DC - 1; i++) begin
                step();
                check_kout(4'h0, "glitch_low");
            end
            key_n_in[1] = 1'b1;
            for (int i = 0; i < 5; i++) begin
                step();
                check_kout(4'h0, "glitch_high");
            end
        end
        wait_drain(4, "glitch");
`ifdef DE2_KEY_DEBOUNCER_GLITCH_CNT_EN
        n_checks++;
        if (glitch_count !== 16'd5) begin
            n_errors++;
            $display("FAIL glitch_count5: glitch_count=%0d, required 5", glitch_count);
        end
        glitch_clr = 1'b1;
        step();
        glitch_clr = 1'b0;
        n_checks++;
        if (glitch_count !== 16'h0) begin
            n_errors++;
            $display("FAIL glitch_clear: glitch_count=%h, required 0000", glitch_count);
        end
`endif
    endtask

    task automatic test_back_to_back();
        key_n_in = 4'b0011;
        push_ev(cyc + LAT, 4'hC, 4'h0, 4'hC);
        for (int i = 1; i <= LAT + 3; i++) begin
            step();
            check_kout((i >= LAT) ? 4'hC : 4'h0, "simul_press");
            key_n_in[0] = ((i % 5) < 3) ? 1'b1 : 1'b0;
        end
        key_n_in = 4'hF;
        push_ev(cyc + LAT, 4'h0, 4'hC, 4'h0);
        for (int i = 1; i <= LAT + 1; i++) begin
            step();
            check_kout((i >= LAT) ? 4'h0 : 4'hC, "simul_release");
        end
        wait_drain(LAT + 4, "back_to_back");
    endtask

    task automatic test_reset_mid_check();
        key_n_in[1] = 1'b0;
        push_ev(cyc + LAT, 4'h2, 4'h0, 4'h2);
        wait_drain(LAT + 4, "prepress");
        key_n_in[0] = 1'b0;
        for (int i = 0; i < 7; i++) begin
            step();
            check_kout(4'h2, "midcheck_before");
        end
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if (key_out !== 4'h0 || press_pulse !== 4'h0 || release_pulse !== 4'h0) begin
                n_errors++;
                $display("FAIL midcheck_reset: key_out=%h press=%h release=%h, required 0/0/0",
                         key_out, press_pulse, release_pulse);
            end
        end
`ifdef DE2_KEY_DEBOUNCER_GLITCH_CNT_EN
        n_checks++;
        if (glitch_count !== 16'h0) begin
            n_errors++;
            $display("FAIL glitch_midreset: glitch_count=%h, required 0000", glitch_count);
        end
`endif
        reset = 1'b0;
        push_ev(cyc + LAT, 4'h3, 4'h0, 4'h3);
        for (int i = 1; i <= LAT + 1; i++) begin
            step();
            check_kout((i >= LAT) ? 4'h3 : 4'h0, "requalify");
        end
        key_n_in = 4'hF;
        push_ev(cyc + LAT, 4'h0, 4'h3, 4'h0);
        wait_drain(LAT + 4, "midcheck");
    endtask

`ifdef DE2_KEY_DEBOUNCER_GLITCH_CNT_EN
    task automatic test_saturation();
        glitch_clr = 1'b1;
        step();
        glitch_clr = 1'b0;
        for (int i = 0; i < 70000; i++) begin
            key_n_in[1:0] = i[0] ? 2'b01 : 2'b10;
            step();
        end
        n_checks++;
        if (glitch_count !== 16'hFFFF) begin
            n_errors++;
            $display("FAIL glitch_saturate: glitch_count=%h, required FFFF", glitch_count);
        end
        for (int i = 0; i < 20; i++) begin
            key_n_in[1:0] = i[0] ? 2'b01 : 2'b10;
            step();
        end
        n_checks++;
        if (glitch_count !== 16'hFFFF) begin
            n_errors++;
            $display("FAIL glitch_hold: glitch_count=%h, required FFFF", glitch_count);
        end
        key_n_in[1:0] = 2'b10;
        glitch_clr = 1'b1;
        step();
        glitch_clr = 1'b0;
        n_checks++;
        if (glitch_count !== 16'h0) begin
            n_errors++;
            $display("FAIL glitch_clr_priority: glitch_count=%h, required 0000", glitch_count);
        end
        for (int i = 1; i <= 3; i++) begin
            key_n_in[1:0] = i[0] ? 2'b01 : 2'b10;
            step();
        end
        n_checks++;
        if (glitch_count !== 16'd3) begin
            n_errors++;
            $display("FAIL glitch_resume: glitch_count=%0d, required 3", glitch_count);
        end
        key_n_in = 4'hF;
        wait_drain(LAT + 4, "saturation");
        check_kout(4'h0, "saturation_idle");
    endtask
`endif

    initial begin
        repeat (2) @(posedge clk);
        test_reset();
        test_press_release();
        test_glitch();
        test_back_to_back();
        test_reset_mid_check();
`ifdef DE2_KEY_DEBOUNCER_GLITCH_CNT_EN
        test_saturation();
`endif
        repeat (5) step();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
